// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: arbitration state and
// the downstream request/response bundles.
package mem_arbiter_pkg;

    // Widest address the downstream request bundle can carry.
    localparam int CBUS_ADDR_W = 64;

    // Instruction fetches are always 4-byte, read-only.
    localparam logic [2:0] FETCH_SIZE = 3'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                   valid;
        logic [CBUS_ADDR_W-1:0] addr;
        logic [2:0]             size;
        logic [7:0]             strobe;
        logic [63:0]            data;
    } cbus_req_t;

    typedef struct packed {
        logic        ok;
        logic [63:0] data;
    } cbus_resp_t;

    // Select the 32-bit instruction word out of a 64-bit beat.
    function automatic logic [31:0] pick_word(input logic [63:0] beat, input logic hi);
        return hi ? beat[63:32] : beat[31:0];
    endfunction

endpackage

// File: rtl/mem_arb_perf.sv
// Grant and wait-cycle counters for the memory arbiter. Only instantiated when
// MEM_ARB_PERF_EN is defined. All counters wrap at 2^32.
module mem_arb_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        igrant,
    input  logic        dgrant,
    input  logic        creq_valid,
    input  logic        cresp_ok,
    output logic [31:0] perf_igrant,
    output logic [31:0] perf_dgrant,
    output logic [31:0] perf_wait
);

    // Count grants per requester and cycles spent waiting on the downstream bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_igrant <= '0;
            perf_dgrant <= '0;
            perf_wait   <= '0;
        end else begin
            if (igrant)
                perf_igrant <= perf_igrant + 32'd1;
            if (dgrant)
                perf_dgrant <= perf_dgrant + 32'd1;
            if (creq_valid && !cresp_ok)
                perf_wait <= perf_wait + 32'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory bus between the instruction and data buses.
// One outstanding transaction; data preferred, with a streak limit so fetches
// always make progress. Optional counters under MEM_ARB_PERF_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4,
    parameter int ADDR_W       = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              iresp_data_ok,
    output logic [31:0]       iresp_data,
    input  logic              dreq_valid,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [2:0]        dreq_size,
    input  logic [7:0]        dreq_strobe,
    input  logic [63:0]       dreq_data,
    output logic              dresp_data_ok,
    output logic [63:0]       dresp_data,
    output logic              creq_valid,
    output logic [ADDR_W-1:0] creq_addr,
    output logic [2:0]        creq_size,
    output logic [7:0]        creq_strobe,
    output logic [63:0]       creq_data,
    input  logic              cresp_ok,
    input  logic [63:0]       cresp_data
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_igrant,
    output logic [31:0]       perf_dgrant,
    output logic [31:0]       perf_wait
`endif
);

    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

    arb_state_t state;
    logic [3:0] streak;
    cbus_req_t  req;
    cbus_resp_t resp;
    logic       grant_d;
    logic       grant_i;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= MAX_STREAK) ? MAX_STREAK : v + 4'd1;
    endfunction

    assign resp = '{ok: cresp_ok, data: cresp_data};

    // Data wins unless it has held the bus MAX_D_STREAK times in a row while a fetch waits.
    assign grant_d = (state == IDLE) && dreq_valid && ((streak < MAX_STREAK) || !ireq_valid);
    assign grant_i = (state == IDLE) && !grant_d && ireq_valid;

    // Arbitration state, streak counter and the latched request that drives creq_*.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            streak <= '0;
            req    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state  <= BUSY_D;
                        streak <= sat_inc(streak);
                        req    <= '{valid:  1'b1,
                                    addr:   CBUS_ADDR_W'(dreq_addr),
                                    size:   dreq_size,
                                    strobe: dreq_strobe,
                                    data:   dreq_data};
                    end else if (grant_i) begin
                        state  <= BUSY_I;
                        streak <= '0;
                        req    <= '{valid:  1'b1,
                                    addr:   CBUS_ADDR_W'(ireq_addr),
                                    size:   FETCH_SIZE,
                                    strobe: 8'h00,
                                    data:   64'h0};
                    end
                end
                BUSY_I, BUSY_D: begin
                    // Completion always returns to IDLE so the requester can
                    // update before the next arbitration.
                    if (resp.ok) begin
                        state <= IDLE;
                        req   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= '0;
                end
            endcase
        end
    end

    assign creq_valid  = req.valid;
    assign creq_addr   = req.addr[ADDR_W-1:0];
    assign creq_size   = req.size;
    assign creq_strobe = req.strobe;
    assign creq_data   = req.data;

    // Responses are routed only to the current owner; reset suppresses a racing completion.
    assign iresp_data_ok = (state == BUSY_I) && resp.ok && !reset;
    assign dresp_data_ok = (state == BUSY_D) && resp.ok && !reset;
    assign iresp_data    = iresp_data_ok ? pick_word(resp.data, req.addr[2]) : 32'h0;
    assign dresp_data    = dresp_data_ok ? resp.data : 64'h0;

`ifdef MEM_ARB_PERF_EN
    mem_arb_perf u_perf (
        .clk         (clk),
        .reset       (reset),
        .igrant      (grant_i),
        .dgrant      (grant_d),
        .creq_valid  (creq_valid),
        .cresp_ok    (cresp_ok),
        .perf_igrant (perf_igrant),
        .perf_dgrant (perf_dgrant),
        .perf_wait   (perf_wait)
    );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: transaction-level reference model plus directed
// scenarios and a randomized phase. Perf counters checked under MEM_ARB_PERF_EN.
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int MAX_D = 4;
    localparam int AW    = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          ireq_valid;
    logic [AW-1:0] ireq_addr;
    logic          iresp_data_ok;
    logic [31:0]   iresp_data;
    logic          dreq_valid;
    logic [AW-1:0] dreq_addr;
    logic [2:0]    dreq_size;
    logic [7:0]    dreq_strobe;
    logic [63:0]   dreq_data;
    logic          dresp_data_ok;
    logic [63:0]   dresp_data;
    logic          creq_valid;
    logic [AW-1:0] creq_addr;
    logic [2:0]    creq_size;
    logic [7:0]    creq_strobe;
    logic [63:0]   creq_data;
    logic          cresp_ok;
    logic [63:0]   cresp_data;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]   perf_igrant;
    logic [31:0]   perf_dgrant;
    logic [31:0]   perf_wait;
`endif

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_D_STREAK(MAX_D), .ADDR_W(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .creq_valid    (creq_valid),
        .creq_addr     (creq_addr),
        .creq_size     (creq_size),
        .creq_strobe   (creq_strobe),
        .creq_data     (creq_data),
        .cresp_ok      (cresp_ok),
        .cresp_data    (cresp_data)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_igrant   (perf_igrant),
        .perf_dgrant   (perf_dgrant),
        .perf_wait     (perf_wait)
`endif
    );

    int total = 0;
    int bad   = 0;

    // Reference model: who holds the bus, what it asked for, grant history since reset.
    int          owner = 0;          // 0 none, 1 fetch, 2 data
    logic [63:0] x_addr;
    logic [2:0]  x_size;
    logic [7:0]  x_strobe;
    logic [63:0] x_data;
    int          glog[$];
    int          icnt = 0, dcnt = 0, wcnt = 0;
    bit          i_done = 0, d_done = 0;

    // Memory agent controls.
    int          mem_delay = 0;
    int          fixed_lat = -1;
    bit          use_fixed_data = 0;
    logic [63:0] fixed_data = 64'h0;
    bit          mem_auto = 1;
    bit          stray_ok = 0;

    // Observations of the DUT.
    int          cyc = 0;
    int          ipulses = 0, dpulses = 0, obs_wait = 0, last_dok_cyc = 0;
    logic [31:0] last_idata;
    bit          prev_cv = 0;
    int          seen[$];
    int          seen_cyc[$];
    logic [63:0] seen_addr[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int trailing_d();
        int n = 0;
        for (int k = glog.size() - 1; k >= 0; k--) begin
            if (glog[k] != 2) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [63:0] rand_iaddr();
        return {32'h0, 4'h8, 26'($urandom), 2'b00};
    endfunction

    function automatic logic [63:0] rand_daddr();
        return {32'h0, 4'h9, 28'($urandom)};
    endfunction

    task automatic new_dreq(input int pd);
        dreq_valid  = (int'($urandom_range(0, 99)) < pd);
        dreq_addr   = rand_daddr();
        dreq_size   = 3'($urandom_range(0, 3));
        dreq_strobe = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
        dreq_data   = {$urandom, $urandom};
    endtask

    task automatic clear_obs();
        ipulses = 0; dpulses = 0; obs_wait = 0;
        seen.delete(); seen_cyc.delete(); seen_addr.delete();
    endtask

    // One clock: drive memory, check outputs, advance model, wait for the next negedge.
    task automatic cycle();
        logic        exp_iok, exp_dok;
        logic [31:0] exp_idata;
        logic [63:0] exp_ddata;
        if (mem_auto) begin
            cresp_ok   = 1'b0;
            cresp_data = {$urandom, $urandom};
            if (owner != 0) begin
                if (mem_delay == 0) begin
                    cresp_ok = 1'b1;
                    if (use_fixed_data) cresp_data = fixed_data;
                end else begin
                    mem_delay--;
                end
            end else if (stray_ok) begin
                cresp_ok = ($urandom_range(0, 7) == 0);
            end
        end
        #1;
        check_eq("creq_valid", 64'(creq_valid), 64'(owner != 0));
        if (owner != 0) begin
            check_eq("creq_addr",   creq_addr,          x_addr);
            check_eq("creq_size",   64'(creq_size),     64'(x_size));
            check_eq("creq_strobe", 64'(creq_strobe),   64'(x_strobe));
            check_eq("creq_data",   creq_data,          x_data);
        end
        exp_iok   = (owner == 1) && cresp_ok && !reset;
        exp_dok   = (owner == 2) && cresp_ok && !reset;
        exp_idata = exp_iok ? (x_addr[2] ? cresp_data[63:32] : cresp_data[31:0]) : 32'h0;
        exp_ddata = exp_dok ? cresp_data : 64'h0;
        check_eq("iresp_data_ok", 64'(iresp_data_ok), 64'(exp_iok));
        check_eq("iresp_data",    64'(iresp_data),    64'(exp_idata));
        check_eq("dresp_data_ok", 64'(dresp_data_ok), 64'(exp_dok));
        check_eq("dresp_data",    dresp_data,         exp_ddata);
`ifdef MEM_ARB_PERF_EN
        check_eq("perf_igrant", 64'(perf_igrant), 64'(icnt));
        check_eq("perf_dgrant", 64'(perf_dgrant), 64'(dcnt));
        check_eq("perf_wait",   64'(perf_wait),   64'(wcnt));
`endif
        if (iresp_data_ok) begin ipulses++; last_idata = iresp_data; end
        if (dresp_data_ok) begin dpulses++; last_dok_cyc = cyc; end
        if (creq_valid && !prev_cv) begin
            seen.push_back(creq_addr[31:28] == 4'h9 ? 2 : 1);
            seen_cyc.push_back(cyc);
            seen_addr.push_back(creq_addr);
        end
        if (creq_valid && !cresp_ok && !reset) obs_wait++;
        prev_cv = creq_valid;

        i_done = 0;
        d_done = 0;
        if (reset) begin
            owner = 0; glog.delete(); icnt = 0; dcnt = 0; wcnt = 0;
        end else if (owner != 0) begin
            if (cresp_ok) begin
                if (owner == 1) i_done = 1; else d_done = 1;
                owner = 0;
            end else begin
                wcnt++;
            end
        end else begin
            if (dreq_valid && (trailing_d() < MAX_D || !ireq_valid)) begin
                owner = 2; x_addr = dreq_addr; x_size = dreq_size;
                x_strobe = dreq_strobe; x_data = dreq_data;
                glog.push_back(2); dcnt++;
            end else if (ireq_valid) begin
                owner = 1; x_addr = ireq_addr; x_size = 3'd2;
                x_strobe = 8'h00; x_data = 64'h0;
                glog.push_back(1); icnt++;
            end
            if (owner != 0) mem_delay = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; ireq_valid = 1'b0; dreq_valid = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    // Core-like requesters: hold a request until served, optionally disturb the owner's inputs.
    task automatic drive_random(input int pi, input int pd, input bit scramble);
        if (owner == 1) begin
            if (scramble && $urandom_range(0, 3) == 0) ireq_addr = rand_iaddr();
            if (scramble && $urandom_range(0, 7) == 0) ireq_valid = 1'b0;
        end else if (i_done || !ireq_valid) begin
            ireq_valid = (int'($urandom_range(0, 99)) < pi);
            ireq_addr  = rand_iaddr();
        end
        if (owner == 2) begin
            if (scramble && $urandom_range(0, 3) == 0) dreq_addr = rand_daddr();
            if (scramble && $urandom_range(0, 7) == 0) dreq_valid = 1'b0;
        end else if (d_done || !dreq_valid) begin
            new_dreq(pd);
        end
    endtask

    initial begin
        int exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
        int t1_start;

        reset = 1'b1; ireq_valid = 1'b0; ireq_addr = '0;
        dreq_valid = 1'b0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
        cresp_ok = 1'b0; cresp_data = '0;
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        #1;
        check_eq("rst_creq_valid",  64'(creq_valid),    64'd0);
        check_eq("rst_creq_addr",   creq_addr,          64'd0);
        check_eq("rst_creq_size",   64'(creq_size),     64'd0);
        check_eq("rst_creq_strobe", 64'(creq_strobe),   64'd0);
        check_eq("rst_creq_data",   creq_data,          64'd0);
        check_eq("rst_iresp_ok",    64'(iresp_data_ok), 64'd0);
        check_eq("rst_dresp_ok",    64'(dresp_data_ok), 64'd0);
        check_eq("rst_iresp_data",  64'(iresp_data),    64'd0);
        check_eq("rst_dresp_data",  dresp_data,         64'd0);

        // Single fetch, fixed latency and data.
        clear_obs();
        fixed_lat = 3; use_fixed_data = 1; fixed_data = 64'hAAAA_BBBB_1111_2222;
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0004;
        t1_start = cyc;
        for (int n = 0; n < 12; n++) begin
            if (i_done) ireq_valid = 1'b0;
            cycle();
        end
        check_eq("t1_ipulses", 64'(ipulses), 64'd1);
        check_eq("t1_dpulses", 64'(dpulses), 64'd0);
        check_eq("t1_idata",   64'(last_idata), 64'hAAAA_BBBB);
        check_eq("t1_ntx",     64'(seen.size()), 64'd1);
        if (seen_cyc.size() > 0) check_eq("t1_latency", 64'(seen_cyc[0] - t1_start), 64'd1);

        // Both pending: data first, then fetch after one idle cycle.
        do_reset();
        clear_obs();
        fixed_lat = 1; use_fixed_data = 0;
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0100;
        dreq_valid = 1'b1; dreq_addr = 64'h8000_1000; dreq_size = 3'd3;
        dreq_strobe = 8'hFF; dreq_data = 64'h1234;
        for (int n = 0; n < 12; n++) begin
            if (i_done) ireq_valid = 1'b0;
            if (d_done) dreq_valid = 1'b0;
            cycle();
        end
        check_eq("t2_ntx", 64'(seen.size()), 64'd2);
        if (seen_addr.size() >= 2) begin
            check_eq("t2_first_addr",  seen_addr[0], 64'h8000_1000);
            check_eq("t2_second_addr", seen_addr[1], 64'h8000_0100);
            check_eq("t2_idle_gap",    64'(seen_cyc[1] - last_dok_cyc), 64'd2);
        end
        check_eq("t2_ipulses", 64'(ipulses), 64'd1);
        check_eq("t2_dpulses", 64'(dpulses), 64'd1);

        // Both continuously requesting: streak limit shapes the grant order.
        do_reset();
        clear_obs();
        fixed_lat = -1;
        ireq_valid = 1'b1; ireq_addr = rand_iaddr();
        new_dreq(100);
        for (int n = 0; n < 200 && seen.size() < 10; n++) begin
            drive_random(100, 100, 0);
            cycle();
        end
        check_eq("t3_ntx", 64'(seen.size()), 64'd10);
        for (int k = 0; k < 10 && k < seen.size(); k++)
            check_eq($sformatf("t3_order%0d", k), 64'(seen[k]), 64'(exp_order[k]));
`ifdef MEM_ARB_PERF_EN
        check_eq("t6_dgrant", 64'(perf_dgrant), 64'd8);
        check_eq("t6_igrant", 64'(perf_igrant), 64'd2);
        check_eq("t6_wait",   64'(perf_wait),   64'(obs_wait));
`endif

        // Owner changes its inputs mid-transaction.
        do_reset();
        clear_obs();
        fixed_lat = 3;
        dreq_valid = 1'b1; dreq_addr = 64'h9000_0040; dreq_size = 3'd3;
        dreq_strobe = 8'h00; dreq_data = 64'h0;
        cycle();
        dreq_addr = 64'h9000_0080; dreq_data = 64'hDEAD_BEEF;
        for (int n = 0; n < 10; n++) begin
            if (d_done) dreq_valid = 1'b0;
            cycle();
        end
        check_eq("t4_dpulses", 64'(dpulses), 64'd1);
        check_eq("t4_ntx",     64'(seen.size()), 64'd1);
        if (seen_addr.size() > 0) check_eq("t4_addr", seen_addr[0], 64'h9000_0040);

        // Reset during a fetch, then a late response.
        do_reset();
        clear_obs();
        mem_auto = 0; cresp_ok = 1'b0;
        ireq_valid = 1'b1; ireq_addr = 64'h8000_0008;
        cycle();
        cycle();
        check_eq("t5_busy", 64'(seen.size()), 64'd1);
        reset = 1'b1; ireq_valid = 1'b0;
        cycle();
        reset = 1'b0; cresp_ok = 1'b1; cresp_data = 64'h5555_6666_7777_8888;
        cycle();
        cresp_ok = 1'b0;
        cycle();
        check_eq("t5_ipulses",    64'(ipulses),       64'd0);
        check_eq("t5_creq_valid", 64'(creq_valid),    64'd0);
        check_eq("t5_iresp_data", 64'(iresp_data),    64'd0);
        mem_auto = 1;

        // Randomized traffic with input disturbance, stray responses and random resets.
        do_reset();
        stray_ok = 1; fixed_lat = -1;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b1; ireq_valid = 1'b0; dreq_valid = 1'b0;
            end else begin
                reset = 1'b0;
                drive_random(60, 60, 1);
            end
            cycle();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port memory bus between the core's instruction bus (ibus) and data bus (dbus).
- Sits between `core` and the memory/bridge; the core keeps its separate ibus/dbus handshake (`valid` high until `data_ok`).
- One outstanding transaction at a time. The owner is locked from grant to response.
- Data requests are preferred, with an anti-starvation streak counter guaranteeing fetch progress.

Parameters:
- MAX_D_STREAK, 4, number of consecutive dbus grants after which a pending ibus request wins the next arbitration (1..15).
- ADDR_W, 64, address width of all buses.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ireq_valid  in  1  fetch request pending
- ireq_addr  in  ADDR_W  fetch address (4-byte aligned)
- iresp_data_ok  out  1  one-cycle pulse: fetch complete
- iresp_data  out  32  fetched instruction
- dreq_valid  in  1  data request pending
- dreq_addr  in  ADDR_W  data address
- dreq_size  in  3  log2 bytes (0..3)
- dreq_strobe  in  8  byte write enables; 0 = read
- dreq_data  in  64  write data
- dresp_data_ok  out  1  one-cycle pulse: data access complete
- dresp_data  out  64  read data
- creq_valid  out  1  downstream request
- creq_addr  out  ADDR_W  downstream address
- creq_size  out  3  downstream size
- creq_strobe  out  8  downstream byte enables
- creq_data  out  64  downstream write data
- cresp_ok  in  1  one-cycle pulse: downstream transaction done
- cresp_data  in  64  downstream read data, valid with `cresp_ok`

Behaviour:
- Reset state:
  - State IDLE, `streak` = 0, owner none.
  - All outputs 0: `creq_*`, `iresp_*`, `dresp_*`.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE arbitration, evaluated every cycle:
  - `dreq_valid` and (`streak` < MAX_D_STREAK or !`ireq_valid`) -> BUSY_D; latch dreq fields.
  - Else if `ireq_valid` -> BUSY_I; latch `ireq_addr`, size=2, strobe=0, data=0.
  - Else stay IDLE.
- Request issue:
  - `creq_*` are registered copies of the latched fields.
  - `creq_valid` = 1 only in BUSY_I/BUSY_D, and is held stable until `cresp_ok`.
  - Minimum latency from grant to `creq_valid`: 1 cycle.
- Completion (BUSY_x with `cresp_ok`=1):
  - Pulse the owner's `data_ok` combinationally in the same cycle.
  - `dresp_data` = `cresp_data`.
  - `iresp_data` = `cresp_data[63:32]` if latched addr[2]=1, else `cresp_data[31:0]`.
  - Next state IDLE. A mandatory IDLE cycle follows every completion, so the core's pipeline registers update before re-arbitration and no stale request is re-issued.
- The non-owner's `data_ok` is always 0.
- `cresp_ok` outside BUSY states is ignored.
- Streak counter:
  - Updated on entry to BUSY_D: `streak` + 1, saturating at MAX_D_STREAK.
  - Cleared on entry to BUSY_I.
- Requester inputs changing or `valid` dropping while it owns the bus: ignored. The latched copy is issued and the response is still delivered.
- Simultaneous new request and completion: the new request waits for the IDLE cycle.
- Reset mid-transaction: immediate return to IDLE; no `data_ok` is generated; a late `cresp_ok` is ignored.
- Output registers/state are 4-state clean; `iresp_data`/`dresp_data` are 0 when the respective `data_ok` = 0.

Optional Feature:
- MEM_ARB_PERF_EN defined adds outputs:
  - `perf_igrant` (32 bits), `perf_dgrant` (32 bits): count grants, wrap at 2^32.
  - `perf_wait` (32 bits): counts cycles with `creq_valid` and !`cresp_ok`.
  - All three clear on reset.
- MEM_ARB_PERF_EN undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Add `arb_state_t` (IDLE/BUSY_I/BUSY_D) and `cbus_req_t`/`cbus_resp_t` structs to the `common` package, alongside `ibus_*`/`dbus_*`.
- Natural sub-module `mem_arb_perf`, instantiated only under MEM_ARB_PERF_EN.

Test Plan:
1. Only ireq_valid=1, addr 0x8000_0004; `cresp_ok` 3 cycles after `creq_valid`, data 0xAAAA_BBBB_1111_2222 -> `creq_valid` in 1 cycle, size=2, strobe=0; `iresp_data_ok` pulse with `iresp_data`=0xAAAA_BBBB; `dresp_data_ok` stays 0.
2. ireq and dreq both valid, dreq write addr 0x8000_1000, strobe 0xFF, data 0x1234 -> dbus granted first with fields exact; after completion plus 1 IDLE cycle the ibus is granted.
3. Both continuously valid, MAX_D_STREAK=4 -> grant order D,D,D,D,I,D,D,D,D,I; `streak` resets after each I.
4. Owner dreq changes addr mid-BUSY_D -> `creq_addr` keeps the original value; `dresp_data_ok` still pulses once.
5. Assert reset during BUSY_I, then `cresp_ok` one cycle later -> all outputs 0; no `iresp_data_ok`; state IDLE.
6. MEM_ARB_PERF_EN defined, run scenario 3 for 10 grants -> `perf_dgrant`=8, `perf_igrant`=2, `perf_wait` equals the summed wait cycles.
